// File: rtl/secded_stream_encoder.sv
// secded_stream_encoder
// Streaming extended-Hamming (SECDED) encoder with a two-deep output buffer.
// Data bits fill the non-power-of-two Hamming positions in ascending order.
// Check bits sit at the power-of-two positions. The top bit carries overall
// even parity. A per-word XOR mask lets a decoder testbench receive single
// or double errors on demand.

module secded_stream_encoder #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16,
    localparam int P  = (DATA_W <= 1)  ? 2 :
                        (DATA_W <= 4)  ? 3 :
                        (DATA_W <= 11) ? 4 :
                        (DATA_W <= 26) ? 5 :
                        (DATA_W <= 57) ? 6 : 7,
    localparam int CW = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CW-1:0]     in_inj_mask_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CW-1:0]     out_code_o,
    output logic [CNT_W-1:0]  word_cnt_o
);

    localparam logic [CW-2:0] ONE_POS = {{(CW-2){1'b0}}, 1'b1};

    // Index of the data bit stored at Hamming position pos.
    // pos must not be a power of two. Only data positions below pos are counted.
    function automatic int dataIndexOf(input int pos);
        int idx;
        idx = 0;
        for (int p = 3; p < pos; p++) begin
            if ((p & (p - 1)) != 0) begin
                idx++;
            end
        end
        return idx;
    endfunction

    // Hamming positions covered by check bit j, meaning every position with bit j set.
    // Bit i of the mask corresponds to position i+1.
    function automatic logic [CW-2:0] coverMask(input int j);
        logic [CW-2:0] m;
        m = '0;
        for (int pos = 1; pos < CW; pos++) begin
            if (((pos >> j) & 1) != 0) begin
                m = m | (ONE_POS << (pos - 1));
            end
        end
        return m;
    endfunction

    // Data bits spread into their Hamming positions, with zeros at the check positions
    logic [CW-2:0] dataSpread;
    // Hamming positions 1..CW-1 with the check bits filled in
    logic [CW-2:0] hammingBits;
    // Complete codeword after the overall parity bit and the injection mask
    logic [CW-1:0] codeWord;

    logic                accept;
    logic                transfer;

    logic                outValid_q, outValid_d;
    logic [CW-1:0]       outCode_q,  outCode_d;
    logic                skidValid_q, skidValid_d;
    logic [CW-1:0]       skidCode_q, skidCode_d;
    logic                inReady_q,  inReady_d;
    logic [CNT_W-1:0]    wordCnt_q,  wordCnt_d;

    for (genvar k = 1; k < CW; k++) begin : gPos
        if ((k & (k - 1)) != 0) begin : gData
            assign dataSpread[k-1]  = in_data_i[dataIndexOf(k)];
            assign hammingBits[k-1] = dataSpread[k-1];
        end else begin : gCheck
            assign dataSpread[k-1]  = 1'b0;
            assign hammingBits[k-1] = ^(dataSpread & coverMask($clog2(k)));
        end
    end

    assign codeWord = {^hammingBits, hammingBits} ^ in_inj_mask_i;

    assign accept   = in_valid_i & inReady_q;
    assign transfer = outValid_q & out_ready_i;

    // Next buffer contents.
    // A transfer first drains the output register, refilling it from skid if skid is full.
    // An accepted word then goes to the output register if it is free, or else to skid.
    always_comb begin
        outValid_d  = outValid_q;
        outCode_d   = outCode_q;
        skidValid_d = skidValid_q;
        skidCode_d  = skidCode_q;
        wordCnt_d   = wordCnt_q;

        if (transfer) begin
            wordCnt_d = wordCnt_q + CNT_W'(1);
            if (skidValid_q) begin
                outCode_d   = skidCode_q;
                skidValid_d = 1'b0;
            end else begin
                outValid_d = 1'b0;
            end
        end

        if (accept) begin
            if (!outValid_q || transfer) begin
                outValid_d = 1'b1;
                outCode_d  = codeWord;
            end else begin
                skidValid_d = 1'b1;
                skidCode_d  = codeWord;
            end
        end

        inReady_d = ~skidValid_d;
    end

    // Buffer state, ready flag and delivered-word counter. Reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            outCode_q   <= '0;
            skidValid_q <= 1'b0;
            skidCode_q  <= '0;
            inReady_q   <= 1'b0;
            wordCnt_q   <= '0;
        end else begin
            outValid_q  <= outValid_d;
            outCode_q   <= outCode_d;
            skidValid_q <= skidValid_d;
            skidCode_q  <= skidCode_d;
            inReady_q   <= inReady_d;
            wordCnt_q   <= wordCnt_d;
        end
    end

    assign in_ready_o  = inReady_q;
    assign out_valid_o = outValid_q;
    assign out_code_o  = outCode_q;
    assign word_cnt_o  = wordCnt_q;

endmodule

// File: tb/tb_secded_stream_encoder.sv
// Testbench for secded_stream_encoder.
// The main instance has a 4-bit data width. Wide instances have 32-bit and
// 64-bit data widths. One small instance has a 4-bit counter so counter wrap
// can be exercised.
// Expected codewords come from a position/syndrome formulation of the code.
// Expected buffer behaviour comes from a queue of words held by the encoder.

module tb_secded_stream_encoder;

    logic clk;
    logic rst;

    // Signals for the 4-bit data instance
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [7:0]  in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_code;
    logic [15:0] word_cnt;

    // Signals for the 32-bit data instance
    logic        v32, r32, ir32, ov32;
    logic [31:0] d32;
    logic [38:0] m32, oc32;
    logic [15:0] wc32;

    // Signals for the 64-bit data instance
    logic        v64, r64, ir64, ov64;
    logic [63:0] d64;
    logic [71:0] m64, oc64;
    logic [15:0] wc64;

    // Signals for the instance with the 4-bit counter
    logic        vC, rC, irC, ovC;
    logic [3:0]  dC;
    logic [7:0]  mC, ocC;
    logic [3:0]  wcC;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    int         mCnt;
    bit         mReady;

    int           accepted;
    int           guard;
    bit           rv, rr;
    logic [127:0] obs;
    logic [63:0]  rdata;

    secded_stream_encoder #(.DATA_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_inj_mask_i(in_mask),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_code_o(out_code), .word_cnt_o(word_cnt)
    );

    secded_stream_encoder #(.DATA_W(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid_i(v32), .in_ready_o(ir32),
        .in_data_i(d32), .in_inj_mask_i(m32),
        .out_valid_o(ov32), .out_ready_i(r32),
        .out_code_o(oc32), .word_cnt_o(wc32)
    );

    secded_stream_encoder #(.DATA_W(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid_i(v64), .in_ready_o(ir64),
        .in_data_i(d64), .in_inj_mask_i(m64),
        .out_valid_o(ov64), .out_ready_i(r64),
        .out_code_o(oc64), .word_cnt_o(wc64)
    );

    secded_stream_encoder #(.DATA_W(4), .CNT_W(4)) dutC (
        .clk(clk), .rst(rst),
        .in_valid_i(vC), .in_ready_o(irC),
        .in_data_i(dC), .in_inj_mask_i(mC),
        .out_valid_o(ovC), .out_ready_i(rC),
        .out_code_o(ocC), .word_cnt_o(wcC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder.
    // Data bits go to the non-power-of-two positions. The positions holding
    // a 1 are XORed together, and that sum becomes the check bits, which
    // makes the syndrome of the finished word zero.
    function automatic logic [127:0] refEncode(input logic [127:0] data, input int dw);
        int p, cw, di, syn;
        logic [127:0] code;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        cw = dw + p + 1;
        code = '0;
        di = 0;
        syn = 0;
        for (int k = 1; k < cw; k++) begin
            if ((k & (k - 1)) != 0) begin
                if (data[di]) begin
                    code[k-1] = 1'b1;
                    syn ^= k;
                end
                di++;
            end
        end
        for (int j = 0; j < p; j++) code[(1 << j) - 1] = (((syn >> j) & 1) != 0);
        code[cw-1] = ^code;
        return code;
    endfunction

    function automatic int refSyndrome(input logic [127:0] cwv, input int cw);
        int syn;
        syn = 0;
        for (int k = 1; k < cw; k++) if (cwv[k-1]) syn ^= k;
        return syn;
    endfunction

    // The caller passes cwv zero-extended above the codeword width.
    function automatic int refParity(input logic [127:0] cwv);
        return int'(^cwv);
    endfunction

    // Reference decoder verdict: 0 means clean, 1 means single error, 2 means double error
    function automatic int refClass(input logic [127:0] cwv, input int cw);
        if (refParity(cwv) != 0) return 1;
        if (refSyndrome(cwv, cw) != 0) return 2;
        return 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle on the 4-bit instance, then advance the queue model through the next rising edge.
    // The task then checks the outputs at the following falling edge.
    task automatic applyStimulus(input bit v, input logic [3:0] d, input logic [7:0] m, input bit r);
        bit acc, xf;
        logic [127:0] enc;
        in_valid  = v;
        in_data   = d;
        in_mask   = m;
        out_ready = r;
        xf  = r && (q.size() > 0);
        acc = v && mReady;
        if (xf) begin
            void'(q.pop_front());
            mCnt++;
        end
        if (acc) begin
            enc = refEncode({124'b0, d}, 4);
            q.push_back(enc[7:0] ^ m);
        end
        mReady = (q.size() < 2);
        @(negedge clk);
        checkOutput("out_valid", {127'b0, out_valid}, {127'b0, (q.size() > 0)});
        if (q.size() > 0) checkOutput("out_code", {120'b0, out_code}, {120'b0, q[0]});
        checkOutput("in_ready", {127'b0, in_ready}, {127'b0, mReady});
        checkOutput("word_cnt", {112'b0, word_cnt}, 128'(mCnt % 65536));
    endtask

    // Present one word to a wide instance with the sink always ready, and check the codeword one edge later
    task automatic wideStep(input int dw, input logic [63:0] data, input logic [127:0] mask,
                            output logic [127:0] observed);
        logic vld;
        if (dw == 32) begin
            v32 = 1'b1; d32 = data[31:0]; m32 = mask[38:0];
        end else begin
            v64 = 1'b1; d64 = data; m64 = mask[71:0];
        end
        @(negedge clk);
        v32 = 1'b0;
        v64 = 1'b0;
        observed = (dw == 32) ? {89'b0, oc32} : {56'b0, oc64};
        vld = (dw == 32) ? ov32 : ov64;
        checkOutput("wide_valid", {127'b0, vld}, 128'd1);
        checkOutput("wide_code", observed, refEncode({64'b0, data}, dw) ^ mask);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_data = 0; in_mask = 0; out_ready = 0;
        v32 = 0; d32 = 0; m32 = 0; r32 = 1;
        v64 = 0; d64 = 0; m64 = 0; r64 = 1;
        vC = 0; dC = 0; mC = 0; rC = 1;
        mCnt = 0;
        mReady = 0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", {127'b0, out_valid}, 128'd0);
        checkOutput("rst_ready", {127'b0, in_ready}, 128'd0);
        checkOutput("rst_cnt", {112'b0, word_cnt}, 128'd0);
        checkOutput("rst_code", {120'b0, out_code}, 128'd0);
        rst = 1'b0;

        // in_ready is still low in this cycle, so the word offered here must be ignored
        applyStimulus(1, 4'h7, 8'h00, 1);

        // Directed clean encodings, each visible one edge after it is accepted
        applyStimulus(1, 4'h0, 8'h00, 1);
        checkOutput("dir_0", {120'b0, out_code}, 128'h00);
        applyStimulus(1, 4'hF, 8'h00, 1);
        checkOutput("dir_F", {120'b0, out_code}, 128'hFF);
        applyStimulus(1, 4'h1, 8'h00, 1);
        checkOutput("dir_1", {120'b0, out_code}, 128'h87);
        applyStimulus(1, 4'hB, 8'h00, 1);
        checkOutput("dir_B", {120'b0, out_code}, 128'h55);
        applyStimulus(0, 4'h0, 8'h00, 1);
        checkOutput("dir_cnt", {112'b0, word_cnt}, 128'd4);

        // Error injection on data 0xB
        applyStimulus(1, 4'hB, 8'h04, 1);
        checkOutput("inj_04", {120'b0, out_code}, 128'h51);
        checkOutput("inj_04_class", 128'(refClass({120'b0, out_code}, 8)), 128'd1);
        applyStimulus(1, 4'hB, 8'h80, 1);
        checkOutput("inj_80", {120'b0, out_code}, 128'hD5);
        checkOutput("inj_80_class", 128'(refClass({120'b0, out_code}, 8)), 128'd1);
        applyStimulus(1, 4'hB, 8'h03, 1);
        checkOutput("inj_03", {120'b0, out_code}, 128'h56);
        checkOutput("inj_03_class", 128'(refClass({120'b0, out_code}, 8)), 128'd2);
        applyStimulus(0, 4'h0, 8'h00, 1);

        // Wide widths: clean random words, then a one-hot mask at every position
        for (int n = 0; n < 8; n++) begin
            rdata = {32'b0, $urandom};
            wideStep(32, rdata, '0, obs);
            checkOutput("w32_syn0", 128'(refSyndrome(obs, 39)), 128'd0);
            checkOutput("w32_par0", 128'(refParity(obs)), 128'd0);
            rdata = {$urandom, $urandom};
            wideStep(64, rdata, '0, obs);
            checkOutput("w64_syn0", 128'(refSyndrome(obs, 72)), 128'd0);
            checkOutput("w64_par0", 128'(refParity(obs)), 128'd0);
        end
        for (int k = 0; k < 39; k++) begin
            rdata = {32'b0, $urandom};
            wideStep(32, rdata, 128'(1) << k, obs);
            checkOutput("w32_synk", 128'(refSyndrome(obs, 39)), (k == 38) ? 128'd0 : 128'(k + 1));
            checkOutput("w32_park", 128'(refParity(obs)), 128'd1);
        end
        for (int k = 0; k < 72; k++) begin
            rdata = {$urandom, $urandom};
            wideStep(64, rdata, 128'(1) << k, obs);
            checkOutput("w64_synk", 128'(refSyndrome(obs, 72)), (k == 71) ? 128'd0 : 128'(k + 1));
            checkOutput("w64_park", 128'(refParity(obs)), 128'd1);
        end

        // Counter wrap with a 4-bit counter. After step i, i-1 words have been delivered.
        for (int i = 1; i <= 18; i++) begin
            vC = (i <= 17);
            dC = 4'($urandom);
            @(negedge clk);
            checkOutput("cnt4_wrap", {124'b0, wcC}, 128'((i - 1) % 16));
        end
        vC = 1'b0;

        // Fill both buffer entries under backpressure, then reset asynchronously
        applyStimulus(1, 4'($urandom), 8'h00, 0);
        applyStimulus(1, 4'($urandom), 8'h00, 0);
        applyStimulus(1, 4'($urandom), 8'h00, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_valid", {127'b0, out_valid}, 128'd0);
        checkOutput("arst_ready", {127'b0, in_ready}, 128'd0);
        checkOutput("arst_cnt", {112'b0, word_cnt}, 128'd0);
        q.delete();
        mCnt = 0;
        mReady = 0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 4'($urandom), 8'h00, 1);
        applyStimulus(0, 4'h0, 8'h00, 1);

        // Random streaming with random backpressure
        accepted = 0;
        guard = 0;
        while (accepted < 1000 && guard < 20000) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) != 0);
            if (rv && mReady) accepted++;
            applyStimulus(rv, 4'($urandom), 8'h00, rr);
            guard++;
        end
        for (int n = 0; n < 4; n++) applyStimulus(0, 4'h0, 8'h00, 1);
        checkOutput("stream_done", 128'(accepted), 128'd1000);
        checkOutput("stream_cnt", {112'b0, word_cnt}, 128'd1000);
        checkOutput("stream_empty", {127'b0, out_valid}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
